// File: rtl/nms_frame_ctrl.sv
// Frame sequencer for the NMS filter pipeline: gates exactly one frame of source
// pixels into the pipeline, waits for its outputs to drain, and counts completed frames.
module nms_frame_ctrl #(
  parameter int unsigned WIDTH         = 720,
  parameter int unsigned HEIGHT        = 540,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  input  logic        src_empty,
  input  logic [7:0]  src_dout,
  output logic        src_rd_en,
  output logic        pipe_empty,
  output logic [7:0]  pipe_dout,
  input  logic        pipe_rd_en,
  input  logic        pipe_wr_en,
  output logic [15:0] frame_count
);

  localparam int unsigned PIXEL_COUNT = WIDTH * HEIGHT;
  localparam int unsigned CNT_W       = $clog2(PIXEL_COUNT + 1);
  localparam int unsigned IDLE_W      = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(PIXEL_COUNT - 1);
  localparam logic [CNT_W-1:0]  PIX_MAX   = CNT_W'(PIXEL_COUNT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               timed_out;
  logic               out_inc;
  logic               out_full_next;

  // Outputs are decodes of the registered state; only src_rd_en sees abort.
  assign pipe_dout  = src_dout;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign timeout    = (state == DONE) & timed_out;
  assign pipe_empty = (state == FEED) ? src_empty : 1'b1;
  assign src_rd_en  = (state == FEED) & pipe_rd_en & ~src_empty & ~abort;

  // Output counter saturates so stray writes cannot wrap it.
  assign out_inc       = pipe_wr_en & (out_cnt != PIX_MAX);
  assign out_full_next = (out_cnt == PIX_MAX) | (pipe_wr_en & (out_cnt == PIX_LAST));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      idle_cnt    <= '0;
      timed_out   <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            idle_cnt  <= '0;
            timed_out <= 1'b0;
            state     <= FEED;
          end
        end
        FEED: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            if (src_rd_en) begin
              in_cnt <= in_cnt + CNT_W'(1);
              if (in_cnt == PIX_LAST) state <= DRAIN;
            end
            if (out_inc) out_cnt <= out_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            if (out_inc) out_cnt <= out_cnt + CNT_W'(1);
            idle_cnt <= pipe_wr_en ? '0 : idle_cnt + IDLE_W'(1);
            // Normal completion wins over a coincident timeout.
            if (out_full_next) begin
              state <= DONE;
            end else if (!pipe_wr_en && (idle_cnt == IDLE_LAST)) begin
              state     <= DONE;
              timed_out <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!timed_out) frame_count <= frame_count + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nms_frame_ctrl.sv
// Randomized self-checking bench for nms_frame_ctrl (4x3 frame, drain timeout 8)
// against a frame-level reference model of reads, writes and completion timing.
module tb_nms_frame_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned TO = 8;
  localparam int          PC = W * H;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        src_empty = 1'b1;
  logic [7:0]  src_dout = 8'h00;
  logic        pipe_rd_en = 1'b0;
  logic        pipe_wr_en = 1'b0;
  logic        busy, done, timeout, src_rd_en, pipe_empty;
  logic [7:0]  pipe_dout;
  logic [15:0] frame_count;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_fc = 0;
  logic [7:0]  src_q[$];
  bit          rd_pending = 1'b0;

  always #5 clock = ~clock;

  nms_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .DRAIN_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .timeout(timeout),
    .src_empty(src_empty), .src_dout(src_dout), .src_rd_en(src_rd_en),
    .pipe_empty(pipe_empty), .pipe_dout(pipe_dout),
    .pipe_rd_en(pipe_rd_en), .pipe_wr_en(pipe_wr_en),
    .frame_count(frame_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic update_src();
    src_empty = (src_q.size() == 0);
    src_dout  = src_empty ? 8'h00 : src_q[0];
  endtask

  // Advance to the next falling edge and retire the read accepted on the rising edge.
  task automatic tick();
    logic [7:0] tmp;
    @(negedge clock);
    if (rd_pending) begin
      tmp = src_q.pop_front();
      rd_pending = 1'b0;
    end
    update_src();
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_timeout"}, 32'(timeout), 32'd0);
    check_val({tag, "_src_rd_en"}, 32'(src_rd_en), 32'd0);
    check_val({tag, "_pipe_empty"}, 32'(pipe_empty), 32'd1);
    check_val({tag, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
  endtask

  // One frame: the model tracks how many pixels were read and written and derives
  // when done must appear (1 cycle after the last write, or TO+1 for a timeout).
  task automatic run_frame(input int add_px, input int n_wr, input int abort_at, input bit rst_drain);
    int reads = 0, writes = 0, cyc = 0, rd_done = -1, exp_done = -1, left0;
    bit timed = 1'b0, fin = 1'b0, in_drain, wr_ok, exp_rd;
    for (int i = 0; i < add_px; i++) src_q.push_back(8'($urandom));
    update_src();
    left0 = src_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && cyc < 300) begin
      in_drain = (reads == PC) && (cyc > rd_done);
      if (rst_drain && in_drain) begin
        #1 reset = 1'b0;
        #1;
        exp_fc = 0;
        check_idle("rst_drain");
        src_q.delete();
        rd_pending = 1'b0;
        pipe_rd_en = 1'b0;
        pipe_wr_en = 1'b0;
        update_src();
        return;
      end
      pipe_rd_en = ($urandom_range(0, 3) != 0);
      start      = (cyc == 3);
      abort      = (abort_at > 0) && (reads == abort_at);
      wr_ok      = (writes < n_wr) && (writes < reads) && ((writes < n_wr - 1) || in_drain);
      pipe_wr_en = wr_ok && !abort && (in_drain || ($urandom_range(0, 1) == 1));
      #1;
      exp_rd = (reads < PC) && pipe_rd_en && !src_empty && !abort;
      check_val("src_rd_en", 32'(src_rd_en), 32'(exp_rd));
      check_val("pipe_empty", 32'(pipe_empty), (reads < PC) ? 32'(src_empty) : 32'd1);
      check_val("pipe_dout", 32'(pipe_dout), 32'(src_dout));
      check_val("busy", 32'(busy), 32'd1);
      check_val("done", 32'(done), 32'(cyc == exp_done));
      check_val("timeout", 32'(timeout), 32'((cyc == exp_done) && timed));
      if (cyc == exp_done) fin = 1'b1;
      if (src_rd_en) begin
        reads++;
        rd_pending = 1'b1;
        if (reads == PC) rd_done = cyc;
      end
      if (pipe_wr_en) begin
        writes++;
        if (writes == n_wr) begin
          timed    = (n_wr != PC);
          exp_done = cyc + (timed ? int'(TO) + 1 : 1);
        end
      end
      if (abort) begin
        tick();
        abort = 1'b0;
        pipe_rd_en = 1'b0;
        pipe_wr_en = 1'b0;
        #1;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_fc", 32'(frame_count), 32'(exp_fc));
        return;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    pipe_rd_en = 1'b0;
    pipe_wr_en = 1'b0;
    check_val("frame_finished", 32'(fin), 32'd1);
    check_val("reads", 32'(reads), 32'(PC));
    if (fin && !timed) exp_fc++;
    #1;
    check_val("end_busy", 32'(busy), 32'd0);
    check_val("end_fc", 32'(frame_count), 32'(exp_fc));
    check_val("src_left", 32'(src_q.size()), 32'(left0 - PC));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    update_src();
    tick();
    check_idle("reset");
    reset = 1'b1;
    tick();
    check_idle("post_reset");

    run_frame(12, PC, 0, 1'b0);        // exact frame
    run_frame(20, PC, 0, 1'b0);        // surplus source pixels stay put
    src_q.delete();
    run_frame(12, 10, 0, 1'b0);        // two writes missing -> timeout
    src_q.delete();
    run_frame(20, PC, 5, 1'b0);        // abort after 5 reads
    run_frame(0, PC, 0, 1'b0);         // restart reads a full frame from leftovers
    src_q.delete();
    update_src();

    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check_val("start_abort_idle", 32'(busy), 32'd0);
      tick();
    end
    check_val("fc_before_reset", 32'(frame_count), 32'd3);

    run_frame(12, PC, 0, 1'b1);        // reset mid-drain
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 check_idle("after_rst_release");
    end

    for (int f = 0; f < 8; f++) begin
      tick();
      run_frame($urandom_range(12, 20), ($urandom_range(0, 1) == 1) ? PC : $urandom_range(1, PC), 0, 1'b0);
      src_q.delete();
      update_src();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
